present_enc_ctrl: RTL and testbench



---
 rtl/present_pkg.sv | 49 ++++
 rtl/present_round.sv | 18 +
 rtl/present_enc_ctrl.sv | 126 ++++++++++++
 tb/tb_present_enc_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/present_pkg.sv
// rtl/present_pkg.sv - PRESENT-80 constants, state encoding and round primitives.
package present_pkg;

   localparam int KEY_SIZE   = 80;
   localparam int BLOCK_SIZE = 64;
   localparam int NUM_ROUNDS = 31;
   localparam int ROUND_W    = $clog2(NUM_ROUNDS + 1);

   localparam logic [3:0] SBOX [16] = '{
      4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
      4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
   };

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      OUT  = 2'd2
   } present_state_e;

   function automatic logic [BLOCK_SIZE-1:0] sbox_layer(input logic [BLOCK_SIZE-1:0] s);
      logic [BLOCK_SIZE-1:0] o;
      o = '0;
      for (int j = 0; j < BLOCK_SIZE / 4; j++) begin
         o[4*j +: 4] = SBOX[s[4*j +: 4]];
      end
      return o;
   endfunction

   // Bit i lands on (16*i) mod 63; the top bit stays in place.
   function automatic logic [BLOCK_SIZE-1:0] p_layer(input logic [BLOCK_SIZE-1:0] s);
      logic [BLOCK_SIZE-1:0] o;
      o = '0;
      for (int i = 0; i < BLOCK_SIZE - 1; i++) begin
         o[(16 * i) % (BLOCK_SIZE - 1)] = s[i];
      end
      o[BLOCK_SIZE-1] = s[BLOCK_SIZE-1];
      return o;
   endfunction

   function automatic logic [KEY_SIZE-1:0] ksa_step(input logic [KEY_SIZE-1:0] k,
                                                    input logic [ROUND_W-1:0] r);
      logic [KEY_SIZE-1:0] o;
      o          = {k[18:0], k[KEY_SIZE-1:19]};
      o[79:76]   = SBOX[o[79:76]];
      o[19:15]   = o[19:15] ^ r;
      return o;
   endfunction

endpackage

// File: rtl/present_round.sv
// rtl/present_round.sv - One combinational PRESENT round plus the next round key.
module present_round
   import present_pkg::*;
(
   input  logic [BLOCK_SIZE-1:0] i_state,
   input  logic [KEY_SIZE-1:0]   i_key,
   input  logic [ROUND_W-1:0]    i_round,
   output logic [BLOCK_SIZE-1:0] o_next_state,
   output logic [KEY_SIZE-1:0]   o_next_key
);

   logic [BLOCK_SIZE-1:0] w_keyed;

   assign w_keyed      = i_state ^ i_key[KEY_SIZE-1 -: BLOCK_SIZE];
   assign o_next_state = p_layer(sbox_layer(w_keyed));
   assign o_next_key   = ksa_step(i_key, i_round);

endmodule

// File: rtl/present_enc_ctrl.sv
// rtl/present_enc_ctrl.sv - Iterative PRESENT-80 encryptor, one round per clock,
// key schedule computed on the fly alongside the state.
module present_enc_ctrl #(
   parameter int KEY_SIZE   = 80,
   parameter int BLOCK_SIZE = 64,
   parameter int NUM_ROUNDS = 31
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              in_valid,
   output logic                              in_ready,
   input  logic [BLOCK_SIZE-1:0]             pt_i,
   input  logic [KEY_SIZE-1:0]               key_i,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic [BLOCK_SIZE-1:0]             ct_o,
   output logic                              busy_o,
   output logic [$clog2(NUM_ROUNDS+1)-1:0]   round_o
);

   import present_pkg::present_state_e;
   import present_pkg::IDLE;
   import present_pkg::RUN;
   import present_pkg::OUT;

   localparam int RW = $clog2(NUM_ROUNDS + 1);

   if (KEY_SIZE != 80) begin : g_key_size_check
      $error("present_enc_ctrl: only KEY_SIZE=80 is supported");
   end
   if (BLOCK_SIZE != 64) begin : g_block_size_check
      $error("present_enc_ctrl: only BLOCK_SIZE=64 is supported");
   end

   present_state_e        r_state;
   present_state_e        w_state_nxt;
   logic [BLOCK_SIZE-1:0] r_data;
   logic [KEY_SIZE-1:0]   r_key;
   logic [RW-1:0]         r_round;
   logic [BLOCK_SIZE-1:0] r_ct;
   logic                  r_out_valid;

   logic                  w_accept;
   logic                  w_last;
   logic                  w_handoff;
   logic [BLOCK_SIZE-1:0] w_next_state;
   logic [KEY_SIZE-1:0]   w_next_key;

   // The same round instance also yields the final whitening key on the last round.
   present_round u_round (
      .i_state      (r_data),
      .i_key        (r_key),
      .i_round      (r_round),
      .o_next_state (w_next_state),
      .o_next_key   (w_next_key)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_last      = 1'b0;
      w_handoff   = 1'b0;
      case (r_state)
         IDLE: begin
            if (in_valid) begin
               w_accept    = 1'b1;
               w_state_nxt = RUN;
            end
         end
         RUN: begin
            if (r_round == RW'(NUM_ROUNDS)) begin
               w_last      = 1'b1;
               w_state_nxt = OUT;
            end
         end
         OUT: begin
            if (r_out_valid && out_ready) begin
               w_handoff   = 1'b1;
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_data      <= '0;
         r_key       <= '0;
         r_round     <= '0;
         r_ct        <= '0;
         r_out_valid <= 1'b0;
      end else if (w_accept) begin
         r_data  <= pt_i;
         r_key   <= key_i;
         r_round <= RW'(1);
      end else if (r_state == RUN) begin
         r_data <= w_next_state;
         r_key  <= w_next_key;
         if (w_last) begin
            r_ct        <= w_next_state ^ w_next_key[KEY_SIZE-1 -: BLOCK_SIZE];
            r_out_valid <= 1'b1;
         end else begin
            r_round <= r_round + RW'(1);
         end
      end else if (w_handoff) begin
         r_out_valid <= 1'b0;
         r_round     <= '0;
      end
   end

   assign in_ready  = (r_state == IDLE);
   assign busy_o    = (r_state != IDLE);
   assign out_valid = r_out_valid;
   assign ct_o      = r_ct;
   assign round_o   = r_round;

endmodule

// File: tb/tb_present_enc_ctrl.sv
// tb/tb_present_enc_ctrl.sv - Scoreboard bench for present_enc_ctrl.
module tb_present_enc_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] pt_i;
   logic [79:0] key_i;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] ct_o;
   logic        busy_o;
   logic [4:0]  round_o;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [63:0] sb_q[$];

   localparam logic [63:0] ONES64 = 64'hFFFF_FFFF_FFFF_FFFF;
   localparam logic [79:0] ONES80 = 80'hFFFF_FFFF_FFFF_FFFF_FFFF;

   present_enc_ctrl dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .pt_i      (pt_i),
      .key_i     (key_i),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .ct_o      (ct_o),
      .busy_o    (busy_o),
      .round_o   (round_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Accept one pair, follow it through every round, then hand the result off.
   task automatic run_block(input logic [63:0] pt, input logic [79:0] key,
                            input logic [63:0] exp, input int hold, input bit scramble);
      int          e;
      logic [63:0] ct_hold;
      e = 0;
      while (!in_ready && e < 100) begin
         @(negedge clk);
         e++;
      end
      check("ready before accept", in_ready, 1);
      pt_i     = pt;
      key_i    = key;
      in_valid = 1'b1;
      sb_q.push_back(exp);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      e = 0;
      while (!out_valid && e < 40) begin
         check("round_o", round_o, e + 1);
         check("in_ready while running", in_ready, 0);
         check("busy while running", busy_o, 1);
         if (scramble) begin
            pt_i  = {$urandom, $urandom};
            key_i = {16'($urandom), $urandom, $urandom};
         end
         @(negedge clk);
         e++;
      end
      check("latency edges after accept", e, 31);
      check("round at completion", round_o, 31);
      ct_hold = ct_o;
      for (int h = 0; h < hold; h++) begin
         out_ready = 1'b0;
         @(negedge clk);
         check("ct stable while held", ct_o, ct_hold);
         check("out_valid held", out_valid, 1);
         check("in_ready during OUT", in_ready, 0);
      end
      check("busy during OUT", busy_o, 1);
      out_ready = 1'b1;
      if (out_valid && sb_q.size() > 0) check("ciphertext", ct_o, sb_q.pop_front());
      @(negedge clk);
      out_ready = 1'b0;
      check("out_valid after handoff", out_valid, 0);
      check("in_ready after handoff", in_ready, 1);
      check("round after handoff", round_o, 0);
      check("busy after handoff", busy_o, 0);
   endtask

   task automatic run_back_to_back();
      logic [63:0] pts  [2];
      logic [79:0] keys [2];
      logic [63:0] exps [2];
      int          acc_cyc [2];
      int          ho_cyc  [2];
      int          idx, cyc, nho, viol;
      bit          acc;
      pts  = '{64'h0, ONES64};
      keys = '{ONES80, 80'h0};
      exps = '{64'hE72C46C0F5945049, 64'hA112FFC72F68417B};
      acc_cyc = '{0, 0};
      ho_cyc  = '{0, 0};
      idx = 0; cyc = 0; nho = 0; viol = 0;
      @(negedge clk);
      pt_i      = pts[0];
      key_i     = keys[0];
      in_valid  = 1'b1;
      out_ready = 1'b1;
      while (nho < 2 && cyc < 200) begin
         acc = in_valid && in_ready;
         if (acc && busy_o) viol++;
         if (out_valid && out_ready) begin
            check("b2b in_ready at handoff", in_ready, 0);
            if (sb_q.size() > 0) check("b2b ciphertext", ct_o, sb_q.pop_front());
            ho_cyc[nho] = cyc;
            nho++;
         end
         @(posedge clk);
         if (acc && idx < 2) begin
            sb_q.push_back(exps[idx]);
            acc_cyc[idx] = cyc;
            idx++;
         end
         @(negedge clk);
         cyc++;
         if (acc) begin
            if (idx < 2) begin
               pt_i  = pts[idx];
               key_i = keys[idx];
            end else begin
               in_valid = 1'b0;
            end
         end
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      check("b2b handoff count", nho, 2);
      check("b2b accept count", idx, 2);
      check("b2b accept while busy", viol, 0);
      check("b2b second accept after first handoff", acc_cyc[1] > ho_cyc[0], 1);
      check("b2b accept spacing", acc_cyc[1] - acc_cyc[0], 33);
   endtask

   initial begin
      int e;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      pt_i      = '0;
      key_i     = '0;
      repeat (2) @(negedge clk);
      check("reset out_valid", out_valid, 0);
      check("reset ct_o", ct_o, 0);
      check("reset busy", busy_o, 0);
      check("reset round", round_o, 0);
      rst_n = 1'b1;
      @(negedge clk);
      check("in_ready after reset", in_ready, 1);
      out_ready = 1'b1;
      @(negedge clk);
      check("stray out_ready out_valid", out_valid, 0);
      check("stray out_ready in_ready", in_ready, 1);
      out_ready = 1'b0;

      run_block(64'h0, 80'h0, 64'h5579C1387B228445, 0, 1'b0);
      run_block(64'h0, ONES80, 64'hE72C46C0F5945049, 0, 1'b0);
      run_block(ONES64, 80'h0, 64'hA112FFC72F68417B, 0, 1'b0);
      run_block(ONES64, ONES80, 64'h3333DCD3213210D2, 10, 1'b0);

      run_back_to_back();

      @(negedge clk);
      pt_i     = ONES64;
      key_i    = ONES80;
      in_valid = 1'b1;
      sb_q.push_back(64'h3333DCD3213210D2);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      e = 0;
      while (round_o != 5'd15 && e < 40) begin
         @(negedge clk);
         e++;
      end
      check("reached round 15", round_o, 15);
      rst_n = 1'b0;
      #1;
      check("mid-run reset out_valid", out_valid, 0);
      check("mid-run reset ct_o", ct_o, 0);
      check("mid-run reset busy", busy_o, 0);
      check("mid-run reset round", round_o, 0);
      sb_q.delete();
      repeat (3) @(negedge clk);
      check("held reset busy", busy_o, 0);
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("no stale out_valid", out_valid, 0);
         check("idle after reset", in_ready, 1);
      end
      run_block(64'h0, 80'h0, 64'h5579C1387B228445, 0, 1'b0);

      run_block(64'h0, 80'h0, 64'h5579C1387B228445, 2, 1'b1);

      check("scoreboard drained", sb_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

endmodule
